pipeline_stall_ctrl: RTL and testbench
======================================

Name: pipeline_stall_ctrl

Overview:
Central stall/flush scheduler for the 19-bit 5-stage pipeline. It combines the load-use hazard, the branch-taken flush, multi-cycle EX operations (MUL/DIV unit start/done handshake) and data-memory wait. From these it drives the write enables and bubble/flush controls for the PC and for the IF_ID, ID_EX and EX_MEM registers. It sits beside the decode stage and replaces ad-hoc per-register enable logic with one prioritised controller.

Parameters:
REG_BITS, 3, register-specifier width (8 registers)
MC_TIMEOUT, 64, maximum cycles to wait for mc_done before aborting
CNT_W, 16, width of the saturating stall-cycle counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-low reset
EX_memread  in  1  instruction in EX is a load
EX_rt  in  REG_BITS  destination register of the load in EX
ID_rs  in  REG_BITS  source register 1 of the instruction in ID
ID_rt  in  REG_BITS  source register 2 of the instruction in ID
EX_mcop  in  1  instruction in EX is a multi-cycle op
mc_done  in  1  multi-cycle unit result valid (1-cycle pulse)
branch_taken  in  1  branch resolved taken in EX
mem_ready  in  1  data memory ready; 0 means freeze the pipeline
PCWrite  out  1  PC update enable
IF_IDwrite  out  1  IF_ID register write enable
IF_ID_flush  out  1  clear IF_ID to NOP
ID_EX_write  out  1  ID_EX register write enable
ID_EX_bubble  out  1  load NOP into ID_EX
EX_MEM_write  out  1  EX_MEM register write enable
EX_MEM_bubble  out  1  load NOP into EX_MEM
mc_start  out  1  1-cycle start pulse to the multi-cycle unit
mc_abort  out  1  1-cycle pulse on timeout
hazard  out  1  load-use hazard detected this cycle
mc_err  out  1  sticky timeout flag
stall_cnt  out  CNT_W  saturating count of cycles with PCWrite=0

Behaviour:
- FSM states: RUN, MC_WAIT. Registered state, timeout counter, mc_err and stall_cnt. All other outputs are combinational from state and inputs.
- Reset (reset=0 at a clk edge): state=RUN, timeout=0, mc_err=0, stall_cnt=0. While reset=0, all enables are 1, and all bubble/flush/start/abort/hazard outputs are 0. Reset mid-MC_WAIT returns to RUN without asserting mc_abort.
- Per-cycle priority: mem_ready=0 > MC_WAIT > branch_taken > load-use > mc_start > normal.
- mem_ready=0, any state: all *write enables=0, all bubbles/flush=0, mc_start=0. State, timeout counter and mc_err hold. stall_cnt increments.
- RUN, branch_taken=1: PCWrite=1, IF_ID_flush=1, ID_EX_bubble=1, hazard=0. Branch overrides load-use.
- RUN, load-use (EX_memread & (EX_rt==ID_rs | EX_rt==ID_rt)): hazard=1, PCWrite=0, IF_IDwrite=0, ID_EX_bubble=1. Exactly 1 bubble, because EX_memread drops the next cycle.
- RUN, EX_mcop=1 with no higher-priority event: mc_start=1, EX_MEM_bubble=1, PCWrite=IF_IDwrite=ID_EX_write=0. Next state MC_WAIT, timeout=0.
- MC_WAIT, mc_done=0: PCWrite=IF_IDwrite=ID_EX_write=0, EX_MEM_bubble=1. timeout increments. When timeout reaches MC_TIMEOUT-1: mc_abort=1, mc_err set, next state RUN.
- MC_WAIT, mc_done=1: all enables=1, no bubble; the EX result is captured into EX_MEM. Next state RUN. mc_done and timeout in the same cycle: done wins, no abort.
- mc_done while in RUN is ignored.
- Normal: all enables=1, all bubbles/flush=0.
- stall_cnt increments every cycle with PCWrite=0 and reset=1, saturating at all-ones.

Decomposition:
- Shared package pipe_ctrl_pkg: state encoding (RUN=0, MC_WAIT=1), REG_BITS, NOP encoding used by bubble/flush.
- One sub-module: sat_counter (parameterised width, enable, synchronous active-low clear), instanced for stall_cnt and the timeout counter.

Test Plan:
- reset=0 for 3 cycles, then reset=1 with idle inputs -> all enables=1, stall_cnt=0, state RUN.
- EX_memread=1, EX_rt=3'b010, ID_rt=3'b010, ID_rs=3'b011 for one cycle -> hazard=1, PCWrite=0, IF_IDwrite=0, ID_EX_bubble=1; stall_cnt=1 next cycle.
- Load-use condition plus branch_taken=1 in the same cycle -> hazard=0, IF_ID_flush=1, ID_EX_bubble=1, PCWrite=1.
- EX_mcop=1, then mc_done at the 5th cycle after start -> mc_start pulses once, freeze for 5 cycles, release on the done cycle, stall_cnt=5.
- EX_mcop=1 with mc_done never asserted, MC_TIMEOUT=64 -> mc_abort pulses on the 64th MC_WAIT cycle, mc_err=1 and stays set, state RUN.
- mem_ready=0 for 3 cycles during MC_WAIT, with mc_done asserted on the first cycle after release -> all enables held 0, timeout counter does not advance, stall_cnt +3, release on done.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller: state codes,
// register-specifier width, NOP encoding and the load-use hazard check.
package pipe_ctrl_pkg;

  localparam int unsigned REG_BITS = 3;
  localparam int unsigned INSN_W   = 19;

  localparam logic [0:0] StRun    = 1'b0;
  localparam logic [0:0] StMcWait = 1'b1;

  // All-zero word is the NOP loaded by bubble/flush into the pipeline registers.
  localparam logic [INSN_W-1:0] NOP_INSN = '0;

  function automatic logic load_use(input logic             memread,
                                    input logic [REG_BITS-1:0] ex_rt,
                                    input logic [REG_BITS-1:0] id_rs,
                                    input logic [REG_BITS-1:0] id_rt);
    return memread && ((ex_rt == id_rs) || (ex_rt == id_rt));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with enable and synchronous active-low clear.
module sat_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             clr_ni,
  input  logic             en_i,
  output logic [Width-1:0] cnt_o
);

  logic [Width-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (!clr_ni) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != {Width{1'b1}})) begin
      cnt_q <= cnt_q + Width'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Prioritised stall/flush scheduler: memory wait, multi-cycle EX op, branch flush
// and load-use hazard drive the PC and pipeline-register enables/bubbles.
module pipeline_stall_ctrl #(
  parameter int unsigned REG_BITS   = 3,
  parameter int unsigned MC_TIMEOUT = 64,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                EX_memread,
  input  logic [REG_BITS-1:0] EX_rt,
  input  logic [REG_BITS-1:0] ID_rs,
  input  logic [REG_BITS-1:0] ID_rt,
  input  logic                EX_mcop,
  input  logic                mc_done,
  input  logic                branch_taken,
  input  logic                mem_ready,
  output logic                PCWrite,
  output logic                IF_IDwrite,
  output logic                IF_ID_flush,
  output logic                ID_EX_write,
  output logic                ID_EX_bubble,
  output logic                EX_MEM_write,
  output logic                EX_MEM_bubble,
  output logic                mc_start,
  output logic                mc_abort,
  output logic                hazard,
  output logic                mc_err,
  output logic [CNT_W-1:0]    stall_cnt
);
  import pipe_ctrl_pkg::*;

  localparam int unsigned ToW = $clog2(MC_TIMEOUT + 1);

  logic [0:0]     state_q, state_d;
  logic           mc_err_q, mc_err_d;
  logic [ToW-1:0] timeout;
  logic           to_clr, to_en;
  logic           lu_hit;

  assign lu_hit = load_use(EX_memread, EX_rt, ID_rs, ID_rt);

  always_comb begin
    PCWrite       = 1'b1;
    IF_IDwrite    = 1'b1;
    IF_ID_flush   = 1'b0;
    ID_EX_write   = 1'b1;
    ID_EX_bubble  = 1'b0;
    EX_MEM_write  = 1'b1;
    EX_MEM_bubble = 1'b0;
    mc_start      = 1'b0;
    mc_abort      = 1'b0;
    hazard        = 1'b0;
    state_d       = state_q;
    to_clr        = 1'b0;
    to_en         = 1'b0;

    if (!reset) begin
      state_d = StRun;
    end else if (!mem_ready) begin
      // Full freeze: state and timeout hold, only stall_cnt advances.
      PCWrite      = 1'b0;
      IF_IDwrite   = 1'b0;
      ID_EX_write  = 1'b0;
      EX_MEM_write = 1'b0;
    end else if (state_q == StMcWait) begin
      if (mc_done) begin
        state_d = StRun;
        to_clr  = 1'b1;
      end else begin
        PCWrite       = 1'b0;
        IF_IDwrite    = 1'b0;
        ID_EX_write   = 1'b0;
        EX_MEM_bubble = 1'b1;
        if (timeout == ToW'(MC_TIMEOUT - 1)) begin
          mc_abort = 1'b1;
          state_d  = StRun;
          to_clr   = 1'b1;
        end else begin
          to_en = 1'b1;
        end
      end
    end else if (branch_taken) begin
      IF_ID_flush  = 1'b1;
      ID_EX_bubble = 1'b1;
    end else if (lu_hit) begin
      hazard       = 1'b1;
      PCWrite      = 1'b0;
      IF_IDwrite   = 1'b0;
      ID_EX_bubble = 1'b1;
    end else if (EX_mcop) begin
      mc_start      = 1'b1;
      EX_MEM_bubble = 1'b1;
      PCWrite       = 1'b0;
      IF_IDwrite    = 1'b0;
      ID_EX_write   = 1'b0;
      state_d       = StMcWait;
      to_clr        = 1'b1;
    end
  end

  assign mc_err_d = mc_err_q | mc_abort;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= StRun;
      mc_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      mc_err_q <= mc_err_d;
    end
  end

  assign mc_err = mc_err_q;

  sat_counter #(
    .Width(ToW)
  ) u_timeout (
    .clk_i (clk),
    .clr_ni(reset & ~to_clr),
    .en_i  (to_en),
    .cnt_o (timeout)
  );

  sat_counter #(
    .Width(CNT_W)
  ) u_stall_cnt (
    .clk_i (clk),
    .clr_ni(reset),
    .en_i  (reset & ~PCWrite),
    .cnt_o (stall_cnt)
  );

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed self-checking bench for pipeline_stall_ctrl.
module tb_pipeline_stall_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        EX_memread, EX_mcop, mc_done, branch_taken, mem_ready;
  logic [2:0]  EX_rt, ID_rs, ID_rt;
  logic        PCWrite, IF_IDwrite, IF_ID_flush, ID_EX_write, ID_EX_bubble;
  logic        EX_MEM_write, EX_MEM_bubble, mc_start, mc_abort, hazard, mc_err;
  logic [15:0] stall_cnt;
  logic [9:0]  ctl;

  int n_tests = 0;
  int n_fail  = 0;

  // {PCW, IFW, IFF, IDW, IDB, EXW, EXB, START, ABORT, HAZ}
  localparam logic [9:0] CNormal = 10'b1101010000;
  localparam logic [9:0] CLoad   = 10'b0001110001;
  localparam logic [9:0] CBranch = 10'b1111110000;
  localparam logic [9:0] CStart  = 10'b0000011100;
  localparam logic [9:0] CWait   = 10'b0000011000;
  localparam logic [9:0] CAbort  = 10'b0000011010;
  localparam logic [9:0] CFreeze = 10'b0000000000;

  always #5 clk = ~clk;

  assign ctl = {PCWrite, IF_IDwrite, IF_ID_flush, ID_EX_write, ID_EX_bubble,
                EX_MEM_write, EX_MEM_bubble, mc_start, mc_abort, hazard};

  pipeline_stall_ctrl #(
    .REG_BITS  (3),
    .MC_TIMEOUT(64),
    .CNT_W     (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .EX_memread   (EX_memread),
    .EX_rt        (EX_rt),
    .ID_rs        (ID_rs),
    .ID_rt        (ID_rt),
    .EX_mcop      (EX_mcop),
    .mc_done      (mc_done),
    .branch_taken (branch_taken),
    .mem_ready    (mem_ready),
    .PCWrite      (PCWrite),
    .IF_IDwrite   (IF_IDwrite),
    .IF_ID_flush  (IF_ID_flush),
    .ID_EX_write  (ID_EX_write),
    .ID_EX_bubble (ID_EX_bubble),
    .EX_MEM_write (EX_MEM_write),
    .EX_MEM_bubble(EX_MEM_bubble),
    .mc_start     (mc_start),
    .mc_abort     (mc_abort),
    .hazard       (hazard),
    .mc_err       (mc_err),
    .stall_cnt    (stall_cnt)
  );

  task automatic idle();
    EX_memread = 0; EX_mcop = 0; mc_done = 0; branch_taken = 0; mem_ready = 1;
    EX_rt = 3'd0; ID_rs = 3'd1; ID_rt = 3'd2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    idle();
    reset = 0;
    repeat (3) tick();
    reset = 1;
    #1;
  endtask

  task automatic test_reset();
    idle();
    reset = 0;
    #1;
    n_tests++;
    if (ctl !== CNormal) begin n_fail++; $display("FAIL reset_ctl: got %b want %b", ctl, CNormal); end
    // A would-be mc op during reset must not start anything.
    EX_mcop = 1;
    #1;
    n_tests++;
    if (ctl !== CNormal) begin n_fail++; $display("FAIL reset_mcop: got %b want %b", ctl, CNormal); end
    repeat (3) tick();
    idle();
    reset = 1;
    #1;
    n_tests++;
    if (ctl !== CNormal) begin n_fail++; $display("FAIL rel_ctl: got %b want %b", ctl, CNormal); end
    n_tests++;
    if (stall_cnt !== 16'd0 || mc_err !== 1'b0) begin
      n_fail++; $display("FAIL rel_regs: got cnt=%0d err=%b want 0 0", stall_cnt, mc_err);
    end
    tick();
    n_tests++;
    if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL idle_cnt: got %0d want 0", stall_cnt); end
  endtask

  task automatic test_load_use();
    apply_reset();
    EX_memread = 1; EX_rt = 3'b010; ID_rt = 3'b010; ID_rs = 3'b011;
    #1;
    n_tests++;
    if (ctl !== CLoad) begin n_fail++; $display("FAIL ld_ctl: got %b want %b", ctl, CLoad); end
    tick();
    EX_memread = 0;
    #1;
    n_tests++;
    if (stall_cnt !== 16'd1) begin n_fail++; $display("FAIL ld_cnt: got %0d want 1", stall_cnt); end
    n_tests++;
    if (ctl !== CNormal) begin n_fail++; $display("FAIL ld_after: got %b want %b", ctl, CNormal); end
    // Match on rs, and a non-matching load.
    EX_memread = 1; EX_rt = 3'b101; ID_rs = 3'b101; ID_rt = 3'b000;
    #1;
    n_tests++;
    if (ctl !== CLoad) begin n_fail++; $display("FAIL ld_rs: got %b want %b", ctl, CLoad); end
    ID_rs = 3'b100;
    #1;
    n_tests++;
    if (ctl !== CNormal) begin n_fail++; $display("FAIL ld_nomatch: got %b want %b", ctl, CNormal); end
    idle();
  endtask

  task automatic test_branch_over_load();
    apply_reset();
    EX_memread = 1; EX_rt = 3'b010; ID_rt = 3'b010; ID_rs = 3'b011; branch_taken = 1;
    EX_mcop = 1;
    #1;
    n_tests++;
    if (ctl !== CBranch) begin n_fail++; $display("FAIL br_ctl: got %b want %b", ctl, CBranch); end
    tick();
    idle();
    #1;
    n_tests++;
    if (stall_cnt !== 16'd0 || ctl !== CNormal) begin
      n_fail++; $display("FAIL br_after: got cnt=%0d ctl=%b want 0 %b", stall_cnt, ctl, CNormal);
    end
  endtask

  task automatic test_mc_done();
    apply_reset();
    EX_mcop = 1;
    #1;
    n_tests++;
    if (ctl !== CStart) begin n_fail++; $display("FAIL mc_start_ctl: got %b want %b", ctl, CStart); end
    tick();
    EX_mcop = 0;
    for (int i = 1; i <= 4; i++) begin
      #1;
      n_tests++;
      if (ctl !== CWait) begin n_fail++; $display("FAIL mc_wait%0d: got %b want %b", i, ctl, CWait); end
      tick();
    end
    mc_done = 1;
    #1;
    n_tests++;
    if (ctl !== CNormal) begin n_fail++; $display("FAIL mc_release: got %b want %b", ctl, CNormal); end
    tick();
    mc_done = 0;
    #1;
    n_tests++;
    if (stall_cnt !== 16'd5) begin n_fail++; $display("FAIL mc_cnt: got %0d want 5", stall_cnt); end
    n_tests++;
    if (ctl !== CNormal || mc_err !== 1'b0) begin
      n_fail++; $display("FAIL mc_run: got ctl=%b err=%b want %b 0", ctl, mc_err, CNormal);
    end
  endtask

  task automatic test_mc_timeout();
    apply_reset();
    EX_mcop = 1;
    tick();
    EX_mcop = 0;
    for (int i = 1; i <= 64; i++) begin
      #1;
      n_tests++;
      if (ctl !== ((i == 64) ? CAbort : CWait)) begin
        n_fail++; $display("FAIL to_cyc%0d: got %b want %b", i, ctl, (i == 64) ? CAbort : CWait);
      end
      if (i == 64) begin
        n_tests++;
        if (mc_err !== 1'b0) begin n_fail++; $display("FAIL to_err_early: got %b want 0", mc_err); end
      end
      tick();
    end
    n_tests++;
    if (mc_err !== 1'b1 || ctl !== CNormal) begin
      n_fail++; $display("FAIL to_after: got err=%b ctl=%b want 1 %b", mc_err, ctl, CNormal);
    end
    n_tests++;
    if (stall_cnt !== 16'd65) begin n_fail++; $display("FAIL to_cnt: got %0d want 65", stall_cnt); end
    // mc_done in RUN is ignored; mc_err stays sticky.
    mc_done = 1;
    #1;
    n_tests++;
    if (ctl !== CNormal) begin n_fail++; $display("FAIL done_in_run: got %b want %b", ctl, CNormal); end
    repeat (3) tick();
    mc_done = 0;
    n_tests++;
    if (mc_err !== 1'b1 || stall_cnt !== 16'd65) begin
      n_fail++; $display("FAIL to_sticky: got err=%b cnt=%0d want 1 65", mc_err, stall_cnt);
    end
  endtask

  task automatic test_done_at_timeout();
    apply_reset();
    EX_mcop = 1;
    tick();
    EX_mcop = 0;
    repeat (63) tick();
    mc_done = 1;
    #1;
    n_tests++;
    if (ctl !== CNormal) begin n_fail++; $display("FAIL dt_ctl: got %b want %b", ctl, CNormal); end
    tick();
    mc_done = 0;
    n_tests++;
    if (mc_err !== 1'b0 || stall_cnt !== 16'd64) begin
      n_fail++; $display("FAIL dt_regs: got err=%b cnt=%0d want 0 64", mc_err, stall_cnt);
    end
  endtask

  task automatic test_mem_freeze();
    apply_reset();
    EX_mcop = 1;
    tick();
    EX_mcop = 0;
    tick();
    // Freeze from cycle 2 of MC_WAIT; done is ignored while frozen.
    mem_ready = 0;
    mc_done = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++;
      if (ctl !== CFreeze) begin n_fail++; $display("FAIL fz_cyc%0d: got %b want %b", i, ctl, CFreeze); end
      tick();
    end
    mem_ready = 1;
    #1;
    n_tests++;
    if (ctl !== CNormal) begin n_fail++; $display("FAIL fz_release: got %b want %b", ctl, CNormal); end
    tick();
    mc_done = 0;
    n_tests++;
    if (stall_cnt !== 16'd5) begin n_fail++; $display("FAIL fz_cnt: got %0d want 5", stall_cnt); end
    // Freeze in RUN overrides branch and mc op.
    mem_ready = 0; branch_taken = 1; EX_mcop = 1;
    #1;
    n_tests++;
    if (ctl !== CFreeze) begin n_fail++; $display("FAIL fz_run: got %b want %b", ctl, CFreeze); end
    tick();
    idle();
    #1;
    n_tests++;
    if (ctl !== CNormal || stall_cnt !== 16'd6) begin
      n_fail++; $display("FAIL fz_run_after: got ctl=%b cnt=%0d want %b 6", ctl, stall_cnt, CNormal);
    end
  endtask

  task automatic test_freeze_timeout_hold();
    // Freeze cycles must not count toward the timeout: abort lands 3 cycles late.
    apply_reset();
    EX_mcop = 1;
    tick();
    EX_mcop = 0;
    repeat (10) tick();
    mem_ready = 0;
    repeat (3) tick();
    mem_ready = 1;
    repeat (53) tick();
    #1;
    n_tests++;
    if (ctl !== CAbort) begin n_fail++; $display("FAIL fzto_abort: got %b want %b", ctl, CAbort); end
    tick();
  endtask

  task automatic test_reset_mid_wait();
    apply_reset();
    EX_mcop = 1;
    tick();
    EX_mcop = 0;
    repeat (5) tick();
    reset = 0;
    #1;
    n_tests++;
    if (ctl !== CNormal) begin n_fail++; $display("FAIL rmw_ctl: got %b want %b", ctl, CNormal); end
    tick();
    reset = 1;
    #1;
    n_tests++;
    if (ctl !== CNormal || mc_err !== 1'b0 || stall_cnt !== 16'd0) begin
      n_fail++; $display("FAIL rmw_after: got ctl=%b err=%b cnt=%0d want %b 0 0",
                         ctl, mc_err, stall_cnt, CNormal);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch_over_load();
    test_mc_done();
    test_mc_timeout();
    test_done_at_timeout();
    test_mem_freeze();
    test_freeze_timeout_hold();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
